fp_operand_unit: RTL and testbench

Decode-stage FP operand unit sitting directly upstream of the `fpu` pipeline. It holds the 32×32 floating-point register file and selects the `a`/`b` operands for the FPU, forwarding from the E3 and W stages. It raises a RAW interlock stall when a source is still in flight in E1/E2, and counts stall cycles for testing. Its write port is driven by the FPU writeback bus (`wn`/`wd`/`ww`) and by the FP-load path.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp_regfile_2w2r.sv | 47 ++++
 rtl/fp_operand_unit.sv | 114 +++++++++++
 tb/tb_fp_operand_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants for the FP operand unit and its register file.
// Forward-select encoding, register-number width and FP zero.
package fpu_pkg;

    localparam int RW = 5;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E3 = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;
    localparam logic [1:0] FWD_LD = 2'd3;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Stage hit: a stage only counts when it will write.
    function automatic logic hit(
        input logic          we,
        input logic [RW-1:0] dn,
        input logic [RW-1:0] sn
    );
        return we && (dn == sn);
    endfunction

endpackage

// File: rtl/fp_regfile_2w2r.sv
// FP register file: two read ports, two write ports.
// Port 0 (FPU writeback) beats port 1 (FP load) on the same entry.
module fp_regfile_2w2r
    import fpu_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [RW-1:0] ra,
    input  logic [RW-1:0] rb,
    input  logic          we0,
    input  logic [RW-1:0] wn0,
    input  logic [31:0]   wd0,
    input  logic          we1,
    input  logic [RW-1:0] wn1,
    input  logic [31:0]   wd1,
    output logic [31:0]   qa,
    output logic [31:0]   qb
);

    logic [31:0] mem [NREG];

    // Storage update; reset clears every entry, f0 included.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= FP_ZERO;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we0 && wn0 == RW'(i)) begin
                    mem[i] <= wd0;
                end else if (we1 && wn1 == RW'(i)) begin
                    mem[i] <= wd1;
                end
            end
        end
    end

    // Combinational read ports.
    always_comb begin
        qa = mem[ra];
        qb = mem[rb];
    end

endmodule

// File: rtl/fp_operand_unit.sv
// Decode-stage FP operand unit: regfile, E3/W/load forwarding,
// E1/E2 RAW interlock and a saturating stall-cycle counter.
module fp_operand_unit
    import fpu_pkg::*;
#(
    parameter int NREG = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [RW-1:0]   rs,
    input  logic [RW-1:0]   rt,
    input  logic            use_a,
    input  logic            use_b,
    input  logic [RW-1:0]   e1n,
    input  logic [RW-1:0]   e2n,
    input  logic [RW-1:0]   e3n,
    input  logic [RW-1:0]   wn,
    input  logic            e1w,
    input  logic            e2w,
    input  logic            e3w,
    input  logic            ww,
    input  logic [31:0]     ed,
    input  logic [31:0]     wd,
    input  logic            ld_we,
    input  logic [RW-1:0]   ld_n,
    input  logic [31:0]     ld_d,
    output logic [31:0]     a,
    output logic [31:0]     b,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            st_raw,
    output logic [CNTW-1:0] stall_cnt
);

    logic [31:0] qa;
    logic [31:0] qb;
    logic        pend_a;
    logic        pend_b;

    fp_regfile_2w2r #(
        .NREG (NREG)
    ) u_rf (
        .clk  (clk),
        .clrn (clrn),
        .ra   (rs),
        .rb   (rt),
        .we0  (ww),
        .wn0  (wn),
        .wd0  (wd),
        .we1  (ld_we),
        .wn1  (ld_n),
        .wd1  (ld_d),
        .qa   (qa),
        .qb   (qb)
    );

    // Operand a source select: E3, then W, then load, then regfile.
    always_comb begin
        fwda = FWD_RF;
        if (hit(e3w, e3n, rs)) begin
            fwda = FWD_E3;
        end else if (hit(ww, wn, rs)) begin
            fwda = FWD_W;
        end else if (hit(ld_we, ld_n, rs)) begin
            fwda = FWD_LD;
        end
    end

    // Operand b source select, same priority as a.
    always_comb begin
        fwdb = FWD_RF;
        if (hit(e3w, e3n, rt)) begin
            fwdb = FWD_E3;
        end else if (hit(ww, wn, rt)) begin
            fwdb = FWD_W;
        end else if (hit(ld_we, ld_n, rt)) begin
            fwdb = FWD_LD;
        end
    end

    // Operand muxes driven by the selects above.
    always_comb begin
        unique case (fwda)
            FWD_E3:  a = ed;
            FWD_W:   a = wd;
            FWD_LD:  a = ld_d;
            default: a = qa;
        endcase
        unique case (fwdb)
            FWD_E3:  b = ed;
            FWD_W:   b = wd;
            FWD_LD:  b = ld_d;
            default: b = qb;
        endcase
    end

    // Interlock: a used source still being produced in E1 or E2.
    always_comb begin
        pend_a = hit(e1w, e1n, rs) || hit(e2w, e2n, rs);
        pend_b = hit(e1w, e1n, rt) || hit(e2w, e2n, rt);
        st_raw = (use_a && pend_a) || (use_b && pend_b);
    end

    // Stall-cycle counter, sticks at all-ones.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= '0;
        end else if (st_raw && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_operand_unit.sv
// Directed bench for fp_operand_unit.
// Hand-computed expectations, one checking task.
module tb_fp_operand_unit;

    logic        clk;
    logic        clrn;
    logic [4:0]  rs, rt;
    logic        use_a, use_b;
    logic [4:0]  e1n, e2n, e3n, wn;
    logic        e1w, e2w, e3w, ww;
    logic [31:0] ed, wd;
    logic        ld_we;
    logic [4:0]  ld_n;
    logic [31:0] ld_d;
    logic [31:0] a, b;
    logic [1:0]  fwda, fwdb;
    logic        st_raw;
    logic [15:0] stall_cnt;

    int n_chk;
    int n_fail;

    fp_operand_unit #(
        .NREG (32),
        .CNTW (16)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .rs        (rs),
        .rt        (rt),
        .use_a     (use_a),
        .use_b     (use_b),
        .e1n       (e1n),
        .e2n       (e2n),
        .e3n       (e3n),
        .wn        (wn),
        .e1w       (e1w),
        .e2w       (e2w),
        .e3w       (e3w),
        .ww        (ww),
        .ed        (ed),
        .wd        (wd),
        .ld_we     (ld_we),
        .ld_n      (ld_n),
        .ld_d      (ld_d),
        .a         (a),
        .b         (b),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .st_raw    (st_raw),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        use_a = 0; use_b = 0;
        e1w = 0; e2w = 0; e3w = 0; ww = 0; ld_we = 0;
        e1n = 0; e2n = 0; e3n = 0; wn = 0; ld_n = 0;
        ed = 0; wd = 0; ld_d = 0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        clrn = 0;
        rs = 5'd5;
        rt = 5'd31;
        idle();
        #2;
        check("rst_a", a, 32'h0);
        check("rst_b", b, 32'h0);
        check("rst_fwda", 32'(fwda), 32'd0);
        check("rst_fwdb", 32'(fwdb), 32'd0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        clrn = 1;
        step();

        // W-port write of f3, forwarded in the write cycle
        ww = 1; wn = 5'd3; wd = 32'h3F80_0000; rs = 5'd3;
        #1;
        check("wfwd_sel", 32'(fwda), 32'd2);
        check("wfwd_a", a, 32'h3F80_0000);
        step();
        ww = 0;
        #1;
        check("rf_a", a, 32'h3F80_0000);
        check("rf_sel", 32'(fwda), 32'd0);

        // E1 interlock on rs for two cycles
        e1w = 1; e1n = 5'd7; rs = 5'd7; use_a = 1;
        #1;
        check("e1_st0", 32'(st_raw), 32'd1);
        step();
        check("e1_st1", 32'(st_raw), 32'd1);
        step();
        check("e1_cnt", 32'(stall_cnt), 32'd2);
        use_a = 0;
        #1;
        check("e1_nouse", 32'(st_raw), 32'd0);

        // E2 interlock on rt, then suppressed, then non-writing match
        e1w = 0; e2w = 1; e2n = 5'd8; rt = 5'd8; use_b = 1;
        #1;
        check("e2_st", 32'(st_raw), 32'd1);
        e2w = 0;
        #1;
        check("e2_nowr", 32'(st_raw), 32'd0);
        use_b = 0;
        check("e2_cnt", 32'(stall_cnt), 32'd2);

        // E3 beats W on the same register; stall released
        e3w = 1; e3n = 5'd7; ed = 32'h4049_0FDB;
        ww = 1; wn = 5'd7; wd = 32'h1;
        rs = 5'd7; use_a = 1; e1w = 0;
        #1;
        check("e3_a", a, 32'h4049_0FDB);
        check("e3_sel", 32'(fwda), 32'd1);
        check("e3_st", 32'(st_raw), 32'd0);
        step();
        idle();
        #1;
        check("f7_rf", a, 32'h1);

        // W and load on f9 (W wins); load alone on f10
        ww = 1; wn = 5'd9; wd = 32'hA;
        ld_we = 1; ld_n = 5'd9; ld_d = 32'hB;
        rs = 5'd9;
        #1;
        check("wld_sel", 32'(fwda), 32'd2);
        check("wld_a", a, 32'hA);
        step();
        ww = 0; ld_n = 5'd10; ld_d = 32'hC; rt = 5'd10;
        #1;
        check("f9_rf", a, 32'hA);
        check("ld_sel", 32'(fwdb), 32'd3);
        check("ld_b", b, 32'hC);
        step();
        idle();
        e3n = 5'd10; ed = 32'hFFFF_FFFF;
        #1;
        check("f10_rf", b, 32'hC);
        check("e3_nowr", 32'(fwdb), 32'd0);

        // Long stall saturates the counter
        e1w = 1; e1n = 5'd4; rs = 5'd4; use_a = 1;
        repeat (65539) step();
        check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
        step();
        check("sat_hold", 32'(stall_cnt), 32'hFFFF);

        // Async reset mid-cycle clears counter and storage
        idle();
        rs = 5'd3; rt = 5'd9;
        #1;
        clrn = 0;
        #1;
        check("arst_cnt", 32'(stall_cnt), 32'd0);
        check("arst_a", a, 32'h0);
        check("arst_b", b, 32'h0);
        clrn = 1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
